// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, per-source mask,
// fixed-priority arbitration (index 0 highest) and a REQ/SERVICE handshake with the CPU.
module irq_controller #(
    parameter int          BITS      = 32,
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] PEND_BASE = 32'hF0000100,
    parameter logic [31:0] MASK_BASE = 32'hF0000104,
    parameter logic [31:0] ID_BASE   = 32'hF0000108
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic               re,
    input  logic [BITS-1:0]    memAddr,
    input  logic [BITS-1:0]    dataBusIn,
    output logic [BITS-1:0]    dataBusOut,
    input  logic [NUM_SRC-1:0] irqSrc,
    input  logic               cpuIntEn,
    input  logic               irqAck,
    input  logic               irqDone,
    output logic               irqReq,
    output logic [3:0]         irqId
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] srcPrev;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] riseEdge;
    logic [NUM_SRC-1:0] busClr;
    logic [NUM_SRC-1:0] ackClr;
    logic [NUM_SRC-1:0] idOneHot;
    logic [NUM_SRC-1:0] pendingNext;
    logic [3:0]         winnerId;
    logic               curEligible;
    logic               inService;

    assign eligible    = pending & mask;
    assign riseEdge    = irqSrc & ~srcPrev;
    assign busClr      = (we && memAddr == BITS'(PEND_BASE)) ? dataBusIn[NUM_SRC-1:0] : '0;
    assign ackClr      = (state == REQ && irqAck) ? idOneHot : '0;
    assign curEligible = |(eligible & idOneHot);
    assign inService   = (state == SERVICE);

    // A new edge beats a software clear, but the CPU's ack beats a new edge.
    assign pendingNext = ((pending & ~busClr) | riseEdge) & ~ackClr;

    // NOTE: every always_comb output gets a default before the loop/case so no latch is inferred.
    always_comb begin
        idOneHot = '0;
        winnerId = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idOneHot[i] = (irqId == 4'(i));
        end
        // Walk from lowest priority upward so the lowest set index wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winnerId = 4'(i);
            end
        end
    end

    always_comb begin
        dataBusOut = '0;
        if (re && !we) begin
            if (memAddr == BITS'(PEND_BASE)) begin
                dataBusOut[NUM_SRC-1:0] = pending;
            end else if (memAddr == BITS'(MASK_BASE)) begin
                dataBusOut[NUM_SRC-1:0] = mask;
            end else if (memAddr == BITS'(ID_BASE)) begin
                dataBusOut[4:0] = {inService, irqId};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            mask    <= '0;
            srcPrev <= '0;
            irqReq  <= 1'b0;
            irqId   <= 4'd0;
        end else begin
            srcPrev <= irqSrc;
            pending <= pendingNext;
            if (we && memAddr == BITS'(MASK_BASE)) begin
                mask <= dataBusIn[NUM_SRC-1:0];
            end

            case (state)
                IDLE: begin
                    if (cpuIntEn && |eligible) begin
                        state  <= REQ;
                        irqReq <= 1'b1;
                        irqId  <= winnerId;
                    end
                end
                REQ: begin
                    // irqId stays frozen here; cpuIntEn dropping does not withdraw the request.
                    if (irqAck) begin
                        state  <= SERVICE;
                        irqReq <= 1'b0;
                    end else if (!curEligible) begin
                        state  <= IDLE;
                        irqReq <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (irqDone) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    irqReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a vector table for the main handshake paths,
// then hand-written sequences for nesting, masking, same-cycle priority and reset.
module tb_irq_controller;

    localparam logic [31:0] PEND = 32'hF0000100;
    localparam logic [31:0] MASK = 32'hF0000104;
    localparam logic [31:0] ID   = 32'hF0000108;
    localparam logic [31:0] NONE = 32'hF000010C;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, re;
    logic [31:0] memAddr, dataBusIn, dataBusOut;
    logic [3:0]  irqSrc;
    logic        cpuIntEn, irqAck, irqDone;
    logic        irqReq;
    logic [3:0]  irqId;

    int nChecks = 0;
    int nFails  = 0;

    irq_controller dut (
        .clk(clk),
        .reset(reset),
        .we(we),
        .re(re),
        .memAddr(memAddr),
        .dataBusIn(dataBusIn),
        .dataBusOut(dataBusOut),
        .irqSrc(irqSrc),
        .cpuIntEn(cpuIntEn),
        .irqAck(irqAck),
        .irqDone(irqDone),
        .irqReq(irqReq),
        .irqId(irqId)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  src;
        logic        en;
        logic        ack;
        logic        done;
        logic [31:0] expBus;
        logic        expReq;
        logic [3:0]  expId;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic w, logic r, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                logic e, logic k, logic dn, logic [31:0] eb, logic er, logic [3:0] ei);
        vec_t v;
        v.we = w; v.re = r; v.addr = a; v.din = d; v.src = s;
        v.en = e; v.ack = k; v.done = dn; v.expBus = eb; v.expReq = er; v.expId = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic readChk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        re      = 1'b1;
        memAddr = addr;
        #1;
        check(name, dataBusOut, exp);
        re      = 1'b0;
    endtask

    task automatic chkOut(input string name, input logic expReq, input logic [3:0] expId);
        check({name, ".irqReq"}, 32'(irqReq), 32'(expReq));
        check({name, ".irqId"}, 32'(irqId), 32'(expId));
    endtask

    initial begin
        // Scenario 1: single source, full ack/done handshake.
        vecs[0]  = mk(1, 0, MASK, 32'h4,        4'h0, 1, 0, 0, 32'h00, 0, 4'd0);
        vecs[1]  = mk(0, 1, MASK, 0,            4'h4, 1, 0, 0, 32'h04, 0, 4'd0);
        vecs[2]  = mk(0, 1, PEND, 0,            4'h0, 1, 0, 0, 32'h04, 1, 4'd2);
        vecs[3]  = mk(0, 1, ID,   0,            4'h0, 1, 0, 0, 32'h02, 1, 4'd2);
        vecs[4]  = mk(0, 1, PEND, 0,            4'h0, 1, 1, 0, 32'h04, 0, 4'd2);
        vecs[5]  = mk(0, 1, ID,   0,            4'h0, 1, 0, 0, 32'h12, 0, 4'd2);
        vecs[6]  = mk(0, 1, PEND, 0,            4'h0, 1, 0, 1, 32'h00, 0, 4'd2);
        vecs[7]  = mk(0, 1, ID,   0,            4'h0, 1, 0, 0, 32'h02, 0, 4'd2);
        // Scenario 2: two simultaneous sources, priority then back-to-back.
        vecs[8]  = mk(1, 0, MASK, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 32'h00, 0, 4'd2);
        vecs[9]  = mk(0, 1, MASK, 0,            4'hA, 1, 0, 0, 32'h0F, 0, 4'd2);
        vecs[10] = mk(0, 1, PEND, 0,            4'hA, 1, 0, 0, 32'h0A, 1, 4'd1);
        vecs[11] = mk(0, 1, ID,   0,            4'hA, 1, 1, 0, 32'h01, 0, 4'd1);
        vecs[12] = mk(0, 1, PEND, 0,            4'h0, 1, 0, 0, 32'h08, 0, 4'd1);
        vecs[13] = mk(0, 1, ID,   0,            4'h0, 1, 0, 1, 32'h11, 0, 4'd1);
        vecs[14] = mk(0, 1, ID,   0,            4'h0, 1, 0, 0, 32'h01, 1, 4'd3);
        vecs[15] = mk(0, 1, ID,   0,            4'h0, 1, 1, 0, 32'h03, 0, 4'd3);
        vecs[16] = mk(0, 1, ID,   0,            4'h0, 1, 0, 1, 32'h13, 0, 4'd3);
        // Scenario 3: software clear while in REQ withdraws the request.
        vecs[17] = mk(0, 1, PEND, 0,            4'h4, 1, 0, 0, 32'h00, 0, 4'd3);
        vecs[18] = mk(0, 1, PEND, 0,            4'h0, 1, 0, 0, 32'h04, 1, 4'd2);
        vecs[19] = mk(1, 1, PEND, 32'h4,        4'h0, 1, 0, 0, 32'h00, 1, 4'd2);
        vecs[20] = mk(0, 1, PEND, 0,            4'h0, 1, 0, 0, 32'h00, 0, 4'd2);
        vecs[21] = mk(0, 1, ID,   0,            4'h0, 1, 1, 1, 32'h02, 0, 4'd2);
        vecs[22] = mk(0, 1, NONE, 0,            4'h0, 1, 0, 0, 32'h00, 0, 4'd2);

        reset = 1'b1; we = 0; re = 0; memAddr = 0; dataBusIn = 0;
        irqSrc = 0; cpuIntEn = 0; irqAck = 0; irqDone = 0;
        step();
        step();
        reset = 1'b0;
        chkOut("reset", 0, 4'd0);
        readChk("reset.pend", PEND, 0);
        readChk("reset.mask", MASK, 0);
        readChk("reset.id", ID, 0);

        for (int i = 0; i < 23; i++) begin
            we = vecs[i].we; re = vecs[i].re; memAddr = vecs[i].addr; dataBusIn = vecs[i].din;
            irqSrc = vecs[i].src; cpuIntEn = vecs[i].en; irqAck = vecs[i].ack; irqDone = vecs[i].done;
            #1;
            check($sformatf("vec%0d.bus", i), dataBusOut, vecs[i].expBus);
            step();
            chkOut($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expId);
        end
        we = 0; re = 0; irqAck = 0; irqDone = 0; dataBusIn = 0;

        // Scenario 4: new edge during SERVICE waits for irqDone.
        irqSrc = 4'h2; step();
        irqSrc = 4'h0; step();
        chkOut("s4.req1", 1, 4'd1);
        irqAck = 1; step(); irqAck = 0;
        check("s4.svc.irqReq", 32'(irqReq), 0);
        irqSrc = 4'h1; step();
        irqSrc = 4'h0; step();
        check("s4.nonest.irqReq", 32'(irqReq), 0);
        readChk("s4.pend", PEND, 32'h1);
        readChk("s4.id", ID, 32'h11);
        step();
        check("s4.hold.irqReq", 32'(irqReq), 0);
        irqDone = 1; step(); irqDone = 0;
        check("s4.idle.irqReq", 32'(irqReq), 0);
        step();
        chkOut("s4.req0", 1, 4'd0);
        irqAck = 1; step(); irqAck = 0;
        irqDone = 1; step(); irqDone = 0;

        // Scenario 5: mask and global enable gating, plus same-cycle priority rules.
        we = 1; memAddr = MASK; dataBusIn = 0; step(); we = 0;
        irqSrc = 4'hF; step();
        irqSrc = 4'h0; step();
        check("s5.masked1.irqReq", 32'(irqReq), 0);
        step();
        check("s5.masked2.irqReq", 32'(irqReq), 0);
        readChk("s5.pend", PEND, 32'hF);
        cpuIntEn = 0;
        we = 1; memAddr = MASK; dataBusIn = 32'hF; step(); we = 0;
        step();
        check("s5.noen1.irqReq", 32'(irqReq), 0);
        step();
        check("s5.noen2.irqReq", 32'(irqReq), 0);
        cpuIntEn = 1; step();
        chkOut("s5.req", 1, 4'd0);
        cpuIntEn = 0; step();
        chkOut("s5.encancel", 1, 4'd0);
        cpuIntEn = 1; irqAck = 1; irqSrc = 4'h1; step(); irqAck = 0;
        check("s5.ackbeatsset.irqReq", 32'(irqReq), 0);
        readChk("s5.ackbeatsset.pend", PEND, 32'hE);
        irqSrc = 4'h0; step();
        irqSrc = 4'h2; we = 1; memAddr = PEND; dataBusIn = 32'hF; step(); we = 0;
        readChk("s5.setbeatsclr.pend", PEND, 32'h2);
        irqSrc = 4'h0; irqDone = 1; step(); irqDone = 0;
        step();
        chkOut("s5.req1", 1, 4'd1);

        // Scenario 6: reset while a request is outstanding.
        reset = 1; step();
        chkOut("s6.reset", 0, 4'd0);
        readChk("s6.pend", PEND, 0);
        readChk("s6.mask", MASK, 0);
        readChk("s6.id", ID, 0);
        reset = 0; step();
        check("s6.after.irqReq", 32'(irqReq), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
